// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of ram_stream_reader.
// The master modport is the reader itself; slave is the environment around it.
interface ram_stream_reader_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      input  start, base_addr, length, ram_q, m_ready,
      output busy, done, ram_address, ram_rden, m_data, m_valid, m_last
   );

   modport slave (
      output start, base_addr, length, ram_q, m_ready,
      input  busy, done, ram_address, ram_rden, m_data, m_valid, m_last
   );
endinterface

// File: rtl/ram_stream_reader.sv
// Read-DMA in front of a synchronous RAM read port: fetches a contiguous run of words
// and replays them as a valid/ready stream, issuing only reads it has FIFO room for.
module ram_stream_reader #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clock0,
   input  logic                sclr,
   ram_stream_reader_if.master bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e                r_state;
   logic [ADDR_W-1:0]     r_issue_addr;
   logic [ADDR_W-1:0]     r_last_addr;
   logic [ADDR_W:0]       r_issue_left;
   logic [ADDR_W:0]       r_out_left;
   logic [RD_LATENCY-1:0] r_tag;
   logic [DATA_W-1:0]     r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [CNT_W-1:0] w_inflight;
   logic             w_issue;
   logic             w_valid;
   logic             w_fifo_wr;
   logic             w_fifo_rd;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
         w_inflight = w_inflight + CNT_W'(r_tag[i]);
      end
   end

   // Credit check counts both buffered words and reads still in the RAM pipeline.
   assign w_issue   = (r_state == StFetch) && (r_issue_left != '0) &&
                      ((r_count + w_inflight) < DEPTH_CNT);
   assign w_valid   = (r_count != '0);
   assign w_fifo_wr = r_tag[RD_LATENCY-1];
   assign w_fifo_rd = w_valid && bus.m_ready;

   assign bus.ram_rden    = w_issue;
   assign bus.ram_address = w_issue ? r_issue_addr : r_last_addr;
   assign bus.m_valid     = w_valid;
   assign bus.m_data      = r_fifo[r_rd_ptr];
   assign bus.m_last      = w_valid && (r_out_left == LEN_ONE);
   assign bus.busy        = (r_state != StIdle);
   assign bus.done        = (r_state == StDone);

   always_ff @(posedge clock0) begin
      if (sclr) begin
         r_state      <= StIdle;
         r_issue_addr <= '0;
         r_last_addr  <= '0;
         r_issue_left <= '0;
         r_out_left   <= '0;
      end else begin
         if (w_issue) begin
            r_last_addr  <= r_issue_addr;
            r_issue_addr <= r_issue_addr + ADDR_ONE;
            r_issue_left <= r_issue_left - LEN_ONE;
         end
         if (w_fifo_rd) begin
            r_out_left <= r_out_left - LEN_ONE;
         end
         unique case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_issue_addr <= bus.base_addr;
                  r_issue_left <= bus.length;
                  r_out_left   <= bus.length;
                  r_state      <= (bus.length == '0) ? StDone : StFetch;
               end
            end
            StFetch: begin
               if (w_issue && (r_issue_left == LEN_ONE)) r_state <= StDrain;
            end
            StDrain: begin
               // Leave on the final handshake so done lands exactly one cycle after it.
               if ((r_out_left == '0) || (w_fifo_rd && (r_out_left == LEN_ONE))) begin
                  r_state <= StDone;
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock0) begin
      if (sclr) begin
         r_tag    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_tag <= (r_tag << 1) | RD_LATENCY'(w_issue);
         if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_fifo_wr && !w_fifo_rd) begin
            r_count <= r_count + CNT_ONE;
         end else if (!w_fifo_wr && w_fifo_rd) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock0) begin
      if (w_fifo_wr) r_fifo[r_wr_ptr] <= bus.ram_q;
   end

   ap_no_overflow: assert property (@(posedge clock0) disable iff (sclr)
      !(w_fifo_wr && !w_fifo_rd && (r_count == DEPTH_CNT)));
endmodule
